vram_arbiter: RTL

Two-port arbiter that shares the single 8-bit video RAM between the CRT fetch engine (read-only, 16-bit byte address) and the CPU bus (read/write). It sits between the CRT controller's VAD/vram_cs/vram_complete handshake, the CPU chip-select decode and the physical RAM pins. It sequences each RAM access with a fixed wait-state count and returns a one-cycle completion strobe to the winning requester.

---
 rtl/vram_pkg.sv | 29 ++
 rtl/vram_arbiter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/vram_pkg.sv
// Shared types for the video RAM arbiter and the blocks that talk to it:
// arbiter state encoding, grant encoding and wait-state limits.
package vram_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } vram_state_e;

   typedef enum logic {
      GNT_VID = 1'b0,
      GNT_CPU = 1'b1
   } vram_gnt_e;

   localparam int WAIT_MIN = 1;
   localparam int WAIT_MAX = 15;
   localparam int WCNT_W   = 4;

   // Counter preload for a transfer of w RAM cycles, clamped to the legal range.
   function automatic logic [WCNT_W-1:0] wait_load(input int w);
      int c;
      c = w;
      if (c < WAIT_MIN) c = WAIT_MIN;
      if (c > WAIT_MAX) c = WAIT_MAX;
      return WCNT_W'(c - 1);
   endfunction

endpackage

// File: rtl/vram_arbiter.sv
// Shares the single 8-bit video RAM between the CRT fetch engine and the CPU,
// with a fixed wait-state count per access and a one-cycle completion strobe.
module vram_arbiter
   import vram_pkg::*;
#(
   parameter int WAIT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] vid_addr,
   input  logic        vid_cs,
   output logic [7:0]  vid_do,
   output logic        vid_complete,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_di,
   input  logic        cpu_rw,
   input  logic        cpu_cs,
   output logic [7:0]  cpu_do,
   output logic        cpu_complete,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_dout,
   input  logic [7:0]  mem_din,
   output logic        mem_cs,
   output logic        mem_we
);

   localparam logic [WCNT_W-1:0] WLOAD = wait_load(WAIT);

   vram_state_e       state_q, state_d;
   vram_gnt_e         last_q, last_d;
   vram_gnt_e         gnt;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic [15:0]       addr_q, addr_d;
   logic [7:0]        dout_q, dout_d;
   logic [7:0]        vdo_q, vdo_d;
   logic [7:0]        cdo_q, cdo_d;
   logic              cs_q, cs_d;
   logic              we_q, we_d;
   logic              vcmp_q, vcmp_d;
   logic              ccmp_q, ccmp_d;

   // On a tie the port not served last wins, so neither side waits more than one access.
   function automatic vram_gnt_e pick(
      input logic      v,
      input logic      c,
      input vram_gnt_e last
   );
      if (v && c) return (last == GNT_VID) ? GNT_CPU : GNT_VID;
      return v ? GNT_VID : GNT_CPU;
   endfunction

   assign gnt = pick(vid_cs, cpu_cs, last_q);

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      wcnt_d  = wcnt_q;
      addr_d  = addr_q;
      dout_d  = dout_q;
      vdo_d   = vdo_q;
      cdo_d   = cdo_q;
      cs_d    = cs_q;
      we_d    = we_q;
      vcmp_d  = 1'b0;
      ccmp_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (vid_cs || cpu_cs) begin
               state_d = ACCESS;
               last_d  = gnt;
               wcnt_d  = WLOAD;
               cs_d    = 1'b1;
               if (gnt == GNT_VID) begin
                  addr_d = vid_addr;
                  we_d   = 1'b0;
               end else begin
                  addr_d = cpu_addr;
                  dout_d = cpu_di;
                  we_d   = !cpu_rw;
               end
            end
         end
         ACCESS: begin
            if (wcnt_q == '0) begin
               state_d = DONE;
               cs_d    = 1'b0;
               we_d    = 1'b0;
               if (last_q == GNT_VID) begin
                  vdo_d  = mem_din;
                  vcmp_d = 1'b1;
               end else begin
                  if (!we_q) cdo_d = mem_din;
                  ccmp_d = 1'b1;
               end
            end else begin
               wcnt_d = wcnt_q - WCNT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= GNT_CPU;
         wcnt_q  <= '0;
         addr_q  <= '0;
         dout_q  <= '0;
         vdo_q   <= '0;
         cdo_q   <= '0;
         cs_q    <= 1'b0;
         we_q    <= 1'b0;
         vcmp_q  <= 1'b0;
         ccmp_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         wcnt_q  <= wcnt_d;
         addr_q  <= addr_d;
         dout_q  <= dout_d;
         vdo_q   <= vdo_d;
         cdo_q   <= cdo_d;
         cs_q    <= cs_d;
         we_q    <= we_d;
         vcmp_q  <= vcmp_d;
         ccmp_q  <= ccmp_d;
      end
   end

   assign mem_addr     = addr_q;
   assign mem_dout     = dout_q;
   assign mem_cs       = cs_q;
   assign mem_we       = we_q;
   assign vid_do       = vdo_q;
   assign cpu_do       = cdo_q;
   assign vid_complete = vcmp_q;
   assign cpu_complete = ccmp_q;

endmodule
